// File: rtl/host_cmd_tx.sv
// Host command serializer: turns one command into a run of UART frames.
// Tx_out is registered from the FSM state, so the line lags the FSM by one
// cycle. The last stop bit is followed by one tail cycle in STOP, which
// makes Cmd_ready, Cmd_done and Frame_done line up with the end of the
// stop bit as seen on the line.
module host_cmd_tx #(
  parameter int width = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Cmd_valid,
  input  logic [1:0]       Cmd_type,
  input  logic [3:0]       Addr,
  input  logic [width-1:0] Data0,
  input  logic [width-1:0] Data1,
  input  logic [3:0]       ALU_FUN,
  input  logic [5:0]       Prescale,
  input  logic             Parity_EN,
  input  logic             Parity_type,
  output logic             Cmd_ready,
  output logic             Tx_out,
  output logic             Busy,
  output logic             Frame_done,
  output logic             Cmd_done
);

  localparam int BW = (width > 1) ? $clog2(width) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state_reg;
  logic [5:0]       cnt_reg;
  logic [5:0]       period_reg;
  logic [BW-1:0]    bit_idx_reg;
  logic [1:0]       byte_idx_reg;
  logic [1:0]       type_reg;
  logic [3:0]       addr_reg;
  logic [width-1:0] data0_reg;
  logic [width-1:0] data1_reg;
  logic [3:0]       fun_reg;
  logic             par_en_reg;
  logic             par_odd_reg;
  logic             stop_end_reg;

  logic [width-1:0] cur_byte;
  logic [1:0]       last_byte;
  logic             tx_bit;
  logic             bit_done;

  assign Busy     = ~Cmd_ready;
  assign bit_done = (cnt_reg == period_reg - 6'd1);

  // Select the byte currently being sent and the index of the final byte.
  always_comb begin
    cur_byte  = '0;
    last_byte = 2'd0;
    case (type_reg)
      2'd0: begin
        last_byte = 2'd2;
        case (byte_idx_reg)
          2'd0:    cur_byte = width'(8'hAA);
          2'd1:    cur_byte = width'({4'b0, addr_reg});
          default: cur_byte = data0_reg;
        endcase
      end
      2'd1: begin
        last_byte = 2'd1;
        cur_byte  = (byte_idx_reg == 2'd0) ? width'(8'hBB) : width'({4'b0, addr_reg});
      end
      2'd2: begin
        last_byte = 2'd3;
        case (byte_idx_reg)
          2'd0:    cur_byte = width'(8'hCC);
          2'd1:    cur_byte = data0_reg;
          2'd2:    cur_byte = data1_reg;
          default: cur_byte = width'({4'b0, fun_reg});
        endcase
      end
      default: begin
        last_byte = 2'd1;
        cur_byte  = (byte_idx_reg == 2'd0) ? width'(8'hDD) : width'({4'b0, fun_reg});
      end
    endcase
  end

  // Line level for the bit the FSM is currently in.
  always_comb begin
    tx_bit = 1'b1;
    case (state_reg)
      START:   tx_bit = 1'b0;
      DATA:    tx_bit = cur_byte[bit_idx_reg];
      PARITY:  tx_bit = (^cur_byte) ^ par_odd_reg;
      default: tx_bit = 1'b1;
    endcase
  end

  // Command FSM, bit-period counter and registered outputs.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      period_reg   <= 6'd1;
      bit_idx_reg  <= '0;
      byte_idx_reg <= '0;
      type_reg     <= '0;
      addr_reg     <= '0;
      data0_reg    <= '0;
      data1_reg    <= '0;
      fun_reg      <= '0;
      par_en_reg   <= 1'b0;
      par_odd_reg  <= 1'b0;
      stop_end_reg <= 1'b0;
      Tx_out       <= 1'b1;
      Cmd_ready    <= 1'b1;
      Frame_done   <= 1'b0;
      Cmd_done     <= 1'b0;
    end else begin
      Tx_out       <= tx_bit;
      Frame_done   <= stop_end_reg;
      stop_end_reg <= 1'b0;
      Cmd_done     <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Cmd_valid) begin
            type_reg     <= Cmd_type;
            addr_reg     <= Addr;
            data0_reg    <= Data0;
            data1_reg    <= Data1;
            fun_reg      <= ALU_FUN;
            period_reg   <= (Prescale == 6'd0) ? 6'd1 : Prescale;
            par_en_reg   <= Parity_EN;
            par_odd_reg  <= Parity_type;
            cnt_reg      <= '0;
            bit_idx_reg  <= '0;
            byte_idx_reg <= '0;
            Cmd_ready    <= 1'b0;
            state_reg    <= START;
          end
        end
        START: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            state_reg <= DATA;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            cnt_reg <= '0;
            if (bit_idx_reg == LAST_BIT) begin
              bit_idx_reg <= '0;
              state_reg   <= par_en_reg ? PARITY : STOP;
            end else begin
              bit_idx_reg <= bit_idx_reg + 1'b1;
            end
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        PARITY: begin
          if (bit_done) begin
            cnt_reg   <= '0;
            state_reg <= STOP;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            stop_end_reg <= 1'b1;
            if (byte_idx_reg == last_byte) begin
              cnt_reg <= cnt_reg + 6'd1;
            end else begin
              cnt_reg      <= '0;
              byte_idx_reg <= byte_idx_reg + 2'd1;
              state_reg    <= START;
            end
          end else if (cnt_reg == period_reg) begin
            cnt_reg      <= '0;
            byte_idx_reg <= '0;
            Cmd_ready    <= 1'b1;
            Cmd_done     <= 1'b1;
            state_reg    <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + 6'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_cmd_tx.sv
// Directed bench for host_cmd_tx: a table of commands with hand-computed
// byte and parity sequences, plus sequences for back-to-back acceptance
// and reset in the middle of a frame.
module tb_host_cmd_tx;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic [1:0] ctype;
  logic [3:0] addr;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [3:0] fun;
  logic [5:0] pre;
  logic       pen;
  logic       pty;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       fd;
  logic       cd;

  int checks = 0;
  int passes = 0;

  logic samp_tx  [0:1023];
  logic samp_fd  [0:1023];
  logic samp_cd  [0:1023];
  logic samp_rdy [0:1023];
  logic samp_busy[0:1023];

  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [3:0]  fun;
    logic [5:0]  pre;
    logic        pen;
    logic        pty;
    int          nb;
    logic [31:0] bytes;
    logic [3:0]  par;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  host_cmd_tx #(.width(W)) dut (
    .CLK(clk), .Reset(rst), .Cmd_valid(valid), .Cmd_type(ctype), .Addr(addr),
    .Data0(d0), .Data1(d1), .ALU_FUN(fun), .Prescale(pre), .Parity_EN(pen),
    .Parity_type(pty), .Cmd_ready(ready), .Tx_out(tx), .Busy(busy),
    .Frame_done(fd), .Cmd_done(cd)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic scramble();
    ctype = 2'($urandom);
    addr  = 4'($urandom);
    d0    = 8'($urandom);
    d1    = 8'($urandom);
    fun   = 4'($urandom);
    pre   = 6'($urandom);
    pen   = 1'($urandom);
    pty   = 1'($urandom);
  endtask

  task automatic drive(input vec_t v);
    ctype = v.typ; addr = v.addr; d0 = v.d0; d1 = v.d1;
    fun = v.fun; pre = v.pre; pen = v.pen; pty = v.pty;
  endtask

  task automatic sample(input int k);
    samp_tx[k]   = tx;
    samp_fd[k]   = fd;
    samp_cd[k]   = cd;
    samp_rdy[k]  = ready;
    samp_busy[k] = busy;
  endtask

  // One table entry: accept, record every cycle, then compare the line.
  task automatic run_vec(input vec_t v, input int id);
    int p, nbits, fl, total, kk, wave_err, fd_err, cd_err, rdy_err;
    logic eb;
    logic [7:0] by, exp_by;
    p     = (v.pre == 6'd0) ? 1 : int'(v.pre);
    nbits = W + 2 + (v.pen ? 1 : 0);
    fl    = nbits * p;
    total = fl * v.nb;
    @(negedge clk);
    check("idle_ready", {31'd0, ready}, 32'd1);
    drive(v);
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    scramble();
    check("accept_cycle_tx_high", {31'd0, tx}, 32'd1);
    check("accept_cycle_ready_low", {31'd0, ready}, 32'd0);
    for (int k = 1; k <= total + 1; k++) begin
      @(negedge clk);
      sample(k);
      scramble();
    end
    wave_err = 0;
    for (int f = 0; f < v.nb; f++) begin
      exp_by = v.bytes[8*f +: 8];
      for (int j = 0; j < nbits; j++) begin
        if (j == 0) eb = 1'b0;
        else if (j <= W) eb = exp_by[j-1];
        else if (v.pen && j == W + 1) eb = v.par[f];
        else eb = 1'b1;
        for (int c = 0; c < p; c++) begin
          kk = f * fl + j * p + c + 1;
          if (samp_tx[kk] !== eb) wave_err++;
        end
      end
      for (int j = 0; j < W; j++) by[j] = samp_tx[f * fl + (1 + j) * p + 1];
      check($sformatf("v%0d_byte%0d", id, f), {24'd0, by}, {24'd0, exp_by});
      if (v.pen)
        check($sformatf("v%0d_parity%0d", id, f),
              {31'd0, samp_tx[f * fl + (W + 1) * p + 1]}, {31'd0, v.par[f]});
    end
    fd_err = 0; cd_err = 0; rdy_err = 0;
    for (int k = 1; k <= total + 1; k++) begin
      if (samp_fd[k] !== ((k > 1) && ((k - 1) % fl == 0))) fd_err++;
      if (samp_cd[k] !== (k == total + 1)) cd_err++;
      if (samp_rdy[k] !== (k == total + 1)) rdy_err++;
      if (samp_busy[k] !== ~samp_rdy[k]) rdy_err++;
    end
    check($sformatf("v%0d_wave_errs", id), wave_err, 0);
    check($sformatf("v%0d_frame_done_errs", id), fd_err, 0);
    check($sformatf("v%0d_cmd_done_errs", id), cd_err, 0);
    check($sformatf("v%0d_ready_busy_errs", id), rdy_err, 0);
    @(negedge clk);
    check($sformatf("v%0d_cmd_done_one_cycle", id), {31'd0, cd}, 32'd0);
    $display("vec %0d type %0d bytes %08h prescale %0d: %0d cycles", id, v.typ, v.bytes, v.pre, total);
  endtask

  initial begin
    int rdy_err, cd_err, tx_err;
    vecs[0] = '{2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 6'd8, 1'b0, 1'b0, 3, 32'h003C05AA, 4'b0000};
    vecs[1] = '{2'd2, 4'h0, 8'h12, 8'h34, 4'h1, 6'd4, 1'b1, 1'b0, 4, 32'h013412CC, 4'b1100};
    vecs[2] = '{2'd1, 4'hF, 8'h00, 8'h00, 4'h0, 6'd1, 1'b1, 1'b1, 2, 32'h00000FBB, 4'b0011};
    vecs[3] = '{2'd3, 4'h0, 8'h00, 8'h00, 4'hA, 6'd0, 1'b1, 1'b0, 2, 32'h00000ADD, 4'b0000};
    vecs[4] = '{2'd0, 4'h0, 8'hFF, 8'h00, 4'h0, 6'd2, 1'b1, 1'b1, 3, 32'h00FF00AA, 4'b0111};

    rst = 1'b1; valid = 1'b0;
    scramble();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, fd}, 32'd0);
    check("rst_cmd_done", {31'd0, cd}, 32'd0);
    rst = 1'b0;
    $display("reset checked");

    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Prescale 0 with Cmd_valid held: ignored while busy, accepted in the
    // Cmd_done cycle, next start bit on the edge after that.
    @(negedge clk);
    ctype = 2'd3; fun = 4'h5; pre = 6'd0; pen = 1'b0; pty = 1'b0; addr = 4'h0; d0 = 8'h00; d1 = 8'h00;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rdy_err = 0;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      sample(k);
      if (k <= 20 && samp_rdy[k] !== 1'b0) rdy_err++;
    end
    check("hold_valid_ignored_while_busy", rdy_err, 0);
    check("p0_start_bit_1cycle", {31'd0, samp_tx[1]}, 32'd0);
    check("p0_bit0_1cycle", {31'd0, samp_tx[2]}, 32'd1);
    check("p0_cmd_done_at_21", {31'd0, samp_cd[21]}, 32'd1);
    check("p0_ready_at_21", {31'd0, samp_rdy[21]}, 32'd1);
    @(negedge clk);
    valid = 1'b0;
    check("b2b_accepted", {31'd0, ready}, 32'd0);
    check("b2b_tx_before_start", {31'd0, tx}, 32'd1);
    @(negedge clk);
    check("b2b_start_bit", {31'd0, tx}, 32'd0);
    cd_err = 0;
    for (int k = 24; k <= 43; k++) begin
      @(negedge clk);
      if (k < 43 && cd !== 1'b0) cd_err++;
      if (k == 43) check("b2b_second_cmd_done", {31'd0, cd}, 32'd1);
    end
    check("b2b_no_early_cmd_done", cd_err, 0);
    $display("back-to-back prescale 0 type 3 pair done");

    // Reset after three data bits of the first frame.
    @(negedge clk);
    drive(vecs[0]);
    pre = 6'd4;
    valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      sample(k);
    end
    check("pre_reset_bit2", {31'd0, samp_tx[16]}, 32'd0);
    check("pre_reset_bit0", {31'd0, samp_tx[8]}, 32'd0);
    check("pre_reset_bit1", {31'd0, samp_tx[12]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_tx", {31'd0, tx}, 32'd1);
    check("midreset_ready", {31'd0, ready}, 32'd1);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    tx_err = 0; cd_err = 0; rdy_err = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_err++;
      if (cd !== 1'b0 || fd !== 1'b0) cd_err++;
      if (ready !== 1'b1) rdy_err++;
    end
    check("post_reset_tx_high", tx_err, 0);
    check("post_reset_no_done", cd_err, 0);
    check("post_reset_ready", rdy_err, 0);
    $display("mid-frame reset sequence done");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
